// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding, BCD digit constants and counter sizing.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE    = 4'd9;
    // A digit at or above this value would leave the 0..9 range when doubled.
    localparam logic [3:0] BCD_ADJ_MIN = 4'd5;
    localparam logic [3:0] BCD_ADJ     = 4'd3;

    // Bit and channel counters share one width, large enough for both indices.
    // Kept at least 1 bit so degenerate configurations still elaborate.
    function automatic int cnt_width(input int bin_w, input int channels);
        int m;
        m = (bin_w > channels) ? bin_w : channels;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Bus bundle between the countdown timer (master) and the converter (slave),
// carrying the input transaction and the converted result.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its data steady until that edge; the
// sink may raise or lower ready freely. On the result side, out_valid stays
// high and bcd_out/ovf stay stable until out_ready is seen high.
interface bcd_converter_seq_if #(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*BIN_W-1:0]    bin_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS*DIGITS*4-1:0] bcd_out;
    logic [CHANNELS-1:0]          ovf;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ovf
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: correct every BCD digit that is 5 or more by
// adding 3, then shift the accumulator left by one, bringing in bit_in.
// carry_out is the bit pushed out of the top digit (worth 10^DIGITS).
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [DIGITS*4-1:0] acc_in,
    input  logic                bit_in,
    output logic [DIGITS*4-1:0] acc_out,
    output logic                carry_out
);
    logic [DIGITS*4-1:0] corr;

    // Per-digit add-3 correction; a digit is at most 9 so the sum fits 4 bits.
    always_comb begin
        corr = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_in[d*4 +: 4] >= BCD_ADJ_MIN)
                corr[d*4 +: 4] = acc_in[d*4 +: 4] + BCD_ADJ;
            else
                corr[d*4 +: 4] = acc_in[d*4 +: 4];
        end
        {carry_out, acc_out} = {corr, bit_in};
    end
endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter. One shared dabble step processes one
// bit per cycle, channel 0 first; each channel's result lands in its output
// slot as soon as its last bit is done. Overflow (value >= 10^DIGITS) is the
// sticky OR of the carries out of the top digit.
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_converter_seq_if.slave  bus,
    output state_t              dbg_state
);
    localparam int CW = cnt_width(BIN_W, CHANNELS);
    localparam int AW = DIGITS * 4;
    localparam int DW = CHANNELS * BIN_W;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ch_q, bit_q;
    logic [BIN_W-1:0]       sh_q;       // current channel, MSB consumed first
    logic [DW-1:0]          rest_q;     // channels still waiting, next at LSBs
    logic [AW-1:0]          acc_q;
    logic                   sticky_q;
    logic [CHANNELS*AW-1:0] bcd_q;
    logic [CHANNELS-1:0]    ovf_q;

    logic [AW-1:0]          acc_step;
    logic                   carry_step;
    logic                   accept, last_bit, last_ch;
    logic                   slot_ovf;
    logic [AW-1:0]          slot_val;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .acc_in    (acc_q),
        .bit_in    (sh_q[BIN_W-1]),
        .acc_out   (acc_step),
        .carry_out (carry_step)
    );

    // The final step's carry counts toward overflow, hence the OR here.
    assign slot_ovf = sticky_q | carry_step;
    assign slot_val = (SATURATE && slot_ovf) ? {DIGITS{BCD_NINE}} : acc_step;

    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
    assign dbg_state   = state_q;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake decode; ready/valid are pure state decodes.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        last_bit      = (bit_q == CW'(BIN_W - 1));
        last_ch       = (ch_q == CW'(CHANNELS - 1));
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && last_ch) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on accept, shift one bit per SHIFT cycle, write the
    // finished slot and roll straight into the next channel on its last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q     <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rest_q   <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= '0;
        end else if (accept) begin
            sh_q     <= bus.bin_in[BIN_W-1:0];
            rest_q   <= bus.bin_in >> BIN_W;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            ch_q     <= '0;
            bit_q    <= '0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_q == CW'(c)) begin
                        bcd_q[c*AW +: AW] <= slot_val;
                        ovf_q[c]          <= slot_ovf;
                    end
                end
                if (!last_ch) begin
                    sh_q     <= rest_q[BIN_W-1:0];
                    rest_q   <= rest_q >> BIN_W;
                    acc_q    <= '0;
                    sticky_q <= 1'b0;
                    bit_q    <= '0;
                    ch_q     <= ch_q + 1'b1;
                end
            end else begin
                acc_q    <= acc_step;
                sticky_q <= sticky_q | carry_step;
                sh_q     <= sh_q << 1;
                bit_q    <= bit_q + 1'b1;
            end
        end
    end
endmodule

// File: doc/bcd_converter_seq.md
# bcd_converter_seq

Parametrised, sequential binary-to-BCD converter for the timer display path, replacing per-value divide/modulo digit splitting. It converts CHANNELS unsigned binary values, such as minutes and seconds, into DIGITS BCD digits each. It uses an iterative shift-add-3 (double-dabble) engine shared across channels. The block sits between the countdown timer and the seven-segment driver, with a valid/ready handshake on both sides and per-channel overflow detection with an optional saturate mode.

## Interface
- BIN_W, 6: width of each binary input value.
- DIGITS, 2: BCD digits produced per channel.
- CHANNELS, 2: number of values converted per transaction.
- SATURATE, 0: 1 = overflowing channel outputs all 9s; 0 = outputs value mod 10^DIGITS.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  bin_in holds a transaction.
- in_ready  out  1  block accepts a transaction (high only in IDLE).
- bin_in  in  CHANNELS*BIN_W  packed values; channel c at [c*BIN_W +: BIN_W], channel 0 at LSBs.
- out_valid  out  1  bcd_out/ovf hold a completed result.
- out_ready  in  1  downstream consumes result.
- bcd_out  out  CHANNELS*DIGITS*4  channel c at [c*DIGITS*4 +: DIGITS*4]; digit 0 (ones) at LSBs of each slice.
- ovf  out  CHANNELS  per-channel overflow flag, bit c = value ≥ 10^DIGITS.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid&&in_ready, the block latches bin_in, loads channel 0 into the shift register, clears the BCD accumulator and the sticky overflow, sets ch=0 and bit=0, and moves to SHIFT.
- SHIFT, one bit per cycle:
  - Add 3 to every BCD digit ≥5.
  - Shift the accumulator left by 1, bringing in the binary MSB.
  - If the bit shifted out of the top digit is 1, set the sticky overflow.
- At the last bit (bit==BIN_W-1), the block writes the corrected result into output slot ch, and ovf[ch] from the sticky flag (including the final step). Then:
  - If ch<CHANNELS-1: load the next channel in the same edge, clear the accumulator and sticky flag, set bit=0, and stay in SHIFT.
  - Otherwise: go to DONE.
- DONE: out_valid=1. bcd_out and ovf are stable until out_ready=1, then the block returns to IDLE. out_valid and in_ready are never high together.
- Overflow result: if SATURATE=1, the slot is forced to all 9s; otherwise the truncated accumulator (mod 10^DIGITS) is kept.
- Width rules: BIN_W≥1, DIGITS≥1, CHANNELS≥1. All arithmetic is unsigned. Digit adders are 4-bit; the add-3 step cannot exceed 4 bits because digit ≤9 before correction.
- Reset mid-operation (rst_n low at any time) immediately:
  - sets state to IDLE;
  - clears bcd_out, ovf and out_valid to 0;
  - aborts the transaction in progress, which is not resumed.
- in_valid while not in IDLE is ignored, with no internal queue.

## Timing
- Reset values: bcd_out=0, ovf=0, out_valid=0, in_ready=1 (combinational decode of IDLE).
- Latency: with acceptance at edge E0, out_valid rises after edge E(CHANNELS*BIN_W). This is 12 cycles for the defaults.
- Throughput: one transaction per CHANNELS*BIN_W+2 cycles at minimum. The +2 covers the DONE handshake cycle and one IDLE cycle.
- out_ready sampled high in DONE returns the block to IDLE on that edge. in_ready is high in the following cycle.
- bcd_out changes only at slot writes and at reset. Between acceptance and DONE, slots still show the previous transaction's values until overwritten.

## Structure
- Shared package bcd_pkg holds:
  - the state enum typedef (IDLE/SHIFT/DONE);
  - localparam BCD_NINE=4'd9;
  - a function to compute the counter width as $clog2 of max(BIN_W,CHANNELS).
- Sub-module bcd_dabble_step is purely combinational and parametrised by DIGITS. It takes the accumulator and an incoming bit, and returns the next accumulator and the carry-out bit. It is instantiated once, and the top is this FSM plus the registers.

## Test plan
- Defaults: bin_in={6'd59,6'd7} accepted → out_valid after 12 cycles, bcd_out=16'h5907, ovf=2'b00.
- BIN_W=7, DIGITS=2, CHANNELS=1:
  - bin_in=99 → bcd_out=8'h99, ovf=0.
  - bin_in=100 → bcd_out=8'h00, ovf=1.
  - bin_in=127 → bcd_out=8'h27, ovf=1.
- Same configuration with SATURATE=1: bin_in=100 → bcd_out=8'h99, ovf=1; bin_in=0 → bcd_out=8'h00, ovf=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → bcd_out stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 → IDLE next edge, and the next transaction is accepted.
- Reset mid-SHIFT: assert rst_n=0 at cycle 5 of a conversion → bcd_out=0, ovf=0 and out_valid=0 immediately. After release, in_ready=1 and {6'd0,6'd63} → 16'h0063.
- Exhaustive defaults: all 64×64 input pairs → each channel's digits equal value/10 and value%10, with ovf=0.
